// File: rtl/acc_requant_drain.sv
// rtl/acc_requant_drain.sv - drains accumulator rows, requantizes each column to OUT_W, streams rows out
// Three-stage read/multiply/requant pipeline feeding a 4-entry output FIFO with credit-based read issue.
module acc_requant_drain #(
    parameter int COLS  = 12,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              cfg_num_rows,
    input  logic [15:0]             cfg_mult,
    input  logic [4:0]              cfg_shift,
    input  logic [7:0]              cfg_zero_point,
    output logic                    acc_rd_en,
    output logic [3:0]              acc_rd_addr,
    input  logic [COLS*ACC_W-1:0]   acc_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*OUT_W-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);
    localparam int PW = ACC_W + 18;
    localparam int FD = 4;
    localparam logic [4:0] MAX_ROWS = 5'(DEPTH);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state;
    logic [4:0]             n_rows;
    logic [15:0]            mult_q;
    logic [4:0]             shift_q;
    logic signed [7:0]      zp_q;
    logic [3:0]             addr_q;
    logic                   rd_v, rd_last;
    logic                   p_v, p_last;
    logic signed [PW-1:0]   prod [COLS];
    logic [COLS*OUT_W-1:0]  fifo_data [FD];
    logic [FD-1:0]          fifo_last;
    logic [1:0]             wr_ptr, rd_ptr;
    logic [2:0]             count;
    logic [2:0]             pending;
    logic [COLS*OUT_W-1:0]  req_row;
    logic                   push, pop, last_read;

    // Rows already in the pipeline count against FIFO space so nothing is ever dropped.
    assign pending     = count + {2'b0, rd_v} + {2'b0, p_v};
    assign acc_rd_en   = (state == S_RUN) && (pending < 3'd4);
    assign acc_rd_addr = addr_q;
    assign last_read   = acc_rd_en && ({1'b0, addr_q} == (n_rows - 5'd1));
    assign push        = p_v;
    assign pop         = out_valid && out_ready;
    assign out_valid   = (count != 3'd0);
    assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last    = out_valid && fifo_last[rd_ptr];
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            n_rows  <= '0;
            mult_q  <= '0;
            shift_q <= '0;
            zp_q    <= '0;
            addr_q  <= '0;
            rd_v    <= 1'b0;
            rd_last <= 1'b0;
            p_v     <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_rows  <= (cfg_num_rows > MAX_ROWS) ? MAX_ROWS : cfg_num_rows;
                        mult_q  <= cfg_mult;
                        shift_q <= cfg_shift;
                        zp_q    <= cfg_zero_point;
                        addr_q  <= '0;
                        state   <= (cfg_num_rows == 5'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (acc_rd_en) begin
                        addr_q <= addr_q + 4'd1;
                        if (last_read) state <= S_FLUSH;
                    end
                end
                S_FLUSH: if (pop && out_last) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
            rd_v    <= acc_rd_en;
            rd_last <= last_read;
            p_v     <= rd_v;
            p_last  <= rd_last;
        end
    end

    // Datapath registers carry no reset; they are only consumed when their valid bit is set.
    always_ff @(posedge clk) begin
        for (int c = 0; c < COLS; c++) begin
            prod[c] <= PW'($signed(acc_rd_data[c*ACC_W +: ACC_W])) *
                       $signed({{(PW-16){1'b0}}, mult_q});
        end
    end

    always_comb begin
        logic signed [PW-1:0] rnd, sum, shr, y;
        req_row = '0;
        rnd     = '0;
        sum     = '0;
        shr     = '0;
        y       = '0;
        if (shift_q != 5'd0) rnd = PW'(1) << (shift_q - 5'd1);
        for (int c = 0; c < COLS; c++) begin
            sum = prod[c] + rnd;
            shr = sum >>> shift_q;
            y   = shr + PW'(zp_q);
            if (y > SAT_MAX)
                req_row[c*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
            else if (y < SAT_MIN)
                req_row[c*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
            else
                req_row[c*OUT_W +: OUT_W] = y[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= req_row;
            fifo_last[wr_ptr] <= p_last;
        end
    end
endmodule

// File: tb/tb_acc_requant_drain.sv
// tb/tb_acc_requant_drain.sv - self-checking bench for acc_requant_drain
// Table vectors for arithmetic corners, randomized drains against an integer reference model.
module tb_acc_requant_drain;
    localparam int COLS  = 12;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int DEPTH = 16;
    localparam int RW    = COLS*OUT_W;

    logic                  clk = 1'b0;
    logic                  rst, start, out_ready;
    logic [4:0]            cfg_num_rows, cfg_shift;
    logic [15:0]           cfg_mult;
    logic [7:0]            cfg_zero_point;
    logic                  acc_rd_en, out_valid, out_last, busy, done;
    logic [3:0]            acc_rd_addr;
    logic [COLS*ACC_W-1:0] acc_rd_data;
    logic [RW-1:0]         out_data;

    always #5 clk = ~clk;

    acc_requant_drain #(.COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_rows(cfg_num_rows),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    logic [ACC_W-1:0] bank [DEPTH][COLS];

    always @(posedge clk) begin
        if (acc_rd_en)
            for (int c = 0; c < COLS; c++) acc_rd_data[c*ACC_W +: ACC_W] <= bank[acc_rd_addr][c];
    end

    int tests = 0;
    int fails = 0;
    int first_valid, done_cyc, valid_cnt;
    logic [RW-1:0] last_row;

    function automatic int requant(longint acc, longint mult, int shift, int zp);
        longint p, r;
        p = acc * mult;
        if (shift > 0) r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
        else           r = p;
        r = r + zp;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: ready always 1, mode 1: random ready, mode 2: repeating 1-0-0-1 ready pattern
    task automatic run_drain(input int ncfg, input int mult, input int shift, input int zp,
                             input int mode, input bit inject_start);
        int n, reads, consumed, cyc, busy_cyc, pat;
        bit seen_done, seen_valid, stalled, prev_last;
        logic [RW-1:0] prev_data, exp_row;
        n = (ncfg > 16) ? 16 : ncfg;
        reads = 0; consumed = 0; busy_cyc = 0; pat = 0;
        seen_done = 0; seen_valid = 0; stalled = 0; prev_last = 0; prev_data = '0;
        first_valid = -1; done_cyc = -1; valid_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_num_rows = 5'(ncfg); cfg_mult = 16'(mult); cfg_shift = 5'(shift); cfg_zero_point = 8'(zp);
        out_ready = (mode != 1);
        @(negedge clk);
        start = 1'b0;
        cfg_num_rows = 5'($urandom); cfg_mult = 16'($urandom);
        cfg_shift = 5'($urandom); cfg_zero_point = 8'($urandom);
        cyc = 1;
        while (!seen_done && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = (pat % 4 == 0) || (pat % 4 == 3);
            endcase
            pat++;
            start = inject_start && (cyc == 3);
            if (busy) busy_cyc++;
            if (acc_rd_en) begin
                check("rd_addr", acc_rd_addr, reads % 16);
                reads++;
                check("reads_ahead", (reads - consumed) <= 4, 1);
            end
            if (stalled) check("stall_valid", out_valid, 1);
            if (out_valid) begin
                valid_cnt++;
                if (!seen_valid) first_valid = cyc;
                seen_valid = 1;
                if (stalled) begin
                    check_row("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                if (out_ready) begin
                    for (int c = 0; c < COLS; c++)
                        exp_row[c*OUT_W +: OUT_W] =
                            8'(requant($signed(bank[consumed % 16][c]), mult, shift, zp));
                    check_row("row_data", out_data, exp_row);
                    check("row_last", out_last, consumed == n - 1);
                    last_row = out_data;
                    consumed++;
                end
                prev_data = out_data;
                prev_last = out_last;
            end
            stalled = out_valid && !out_ready;
            if (done) begin
                seen_done = 1;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("rows_out", consumed, n);
        check("reads_issued", reads, n);
        check("busy_cycles", busy_cyc, done_cyc);
        check("done_single", done, 0);
        check("busy_after", busy, 0);
        if (mode == 0 && n > 0) check("throughput", done_cyc - first_valid, n);
    endtask

    typedef struct {
        int acc;
        int mult;
        int shift;
        int zp;
        int exp;
    } vec_t;

    vec_t vt[13];
    logic [RW-1:0] exp_vec;
    int bad;

    initial begin
        vt[0]  = '{1000, 3, 4, -5, 127};
        vt[1]  = '{-100, 5, 3, 10, -52};
        vt[2]  = '{32'sh80000000, 65535, 0, 0, -128};
        vt[3]  = '{32'sh7FFFFFFF, 65535, 31, 127, 127};
        vt[4]  = '{7, 1, 1, 0, 4};
        vt[5]  = '{-7, 1, 1, 0, -3};
        vt[6]  = '{-3, 1, 1, 0, -1};
        vt[7]  = '{100, 1, 0, 27, 127};
        vt[8]  = '{-100, 1, 0, -28, -128};
        vt[9]  = '{5, 0, 0, -128, -128};
        vt[10] = '{-100, 1, 0, -29, -128};
        vt[11] = '{99, 1, 0, 28, 127};
        vt[12] = '{-256, 2, 2, 3, -125};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        cfg_num_rows = '0; cfg_mult = '0; cfg_shift = '0; cfg_zero_point = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", acc_rd_en, 0);
        check("rst_rd_addr", acc_rd_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_row("rst_data", out_data, '0);
        rst = 1'b0;

        for (int k = 0; k < DEPTH; k++)
            for (int c = 0; c < COLS; c++) bank[k][c] = 32'(k);
        run_drain(4, 1, 0, 0, 0, 0);
        check("first_valid", first_valid, 4);
        check("done_cycle", done_cyc, 8);

        for (int i = 0; i < 13; i++) begin
            for (int c = 0; c < COLS; c++) bank[0][c] = vt[i].acc;
            run_drain(1, vt[i].mult, vt[i].shift, vt[i].zp, 0, 0);
            for (int c = 0; c < COLS; c++) exp_vec[c*OUT_W +: OUT_W] = 8'(vt[i].exp);
            check_row("vec_row", last_row, exp_vec);
        end

        run_drain(0, 1, 0, 0, 0, 0);
        check("n0_busy_one", done_cyc, 1);
        check("n0_no_valid", valid_cnt, 0);

        for (int it = 0; it < 7; it++) begin
            for (int k = 0; k < DEPTH; k++)
                for (int c = 0; c < COLS; c++)
                    bank[k][c] = ($urandom % 2) ? $urandom : 32'($signed($urandom_range(0, 4000)) - 2000);
            case (it)
                0:       run_drain(16, $urandom % 65536, $urandom % 32, int'($urandom % 256) - 128, 2, 0);
                1:       run_drain(20, $urandom_range(1, 40), $urandom_range(0, 6), int'($urandom % 256) - 128, 1, 0);
                2:       run_drain(16, 1, 0, 0, 0, 0);
                3:       run_drain($urandom_range(5, 16), $urandom % 300, $urandom % 12, int'($urandom % 256) - 128, 1, 1);
                default: run_drain($urandom_range(1, 31), $urandom % 65536, $urandom % 32,
                                   int'($urandom % 256) - 128, 1, 0);
            endcase
        end

        @(negedge clk);
        start = 1'b1; cfg_num_rows = 5'd16; cfg_mult = 16'd1; cfg_shift = 5'd0; cfg_zero_point = 8'd0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        bad = 0;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || done || acc_rd_en) bad++;
        end
        check("midrst_quiet", bad, 0);

        run_drain(5, 3, 2, 7, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
